// File: rtl/mem_pkg.sv
// mem_pkg: shared constants and helpers for the mem_resp memory responder.
// Holds the I/O window decode, register offsets and status-bit layout.
package mem_pkg;

  // I/O window: ad[IO_SEL_HI:IO_SEL_LO] == IO_SEL selects the register space
  localparam int          IO_SEL_HI   = 17;
  localparam int          IO_SEL_LO   = 16;
  localparam logic [1:0]  IO_SEL      = 2'b11;

  // Register offsets inside the I/O window (ad[15:0])
  localparam logic [15:0] IO_DATA_OFS = 16'h0000;
  localparam logic [15:0] IO_STAT_OFS = 16'h0004;

  // Status byte bit positions
  localparam int          TX_FULL     = 0;
  localparam int          RX_EMPTY    = 1;
  localparam int          OVF         = 2;

  // Which register feeds dout after a read
  typedef enum logic {
    SRC_IO  = 1'b0,
    SRC_RAM = 1'b1
  } rd_src_e;

  // True when the bus address falls in the I/O window
  function automatic logic is_io(input logic [31:0] addr);
    return addr[IO_SEL_HI:IO_SEL_LO] == IO_SEL;
  endfunction

  // Pack the status register from its three flags
  function automatic logic [7:0] pack_status(input logic tx_full,
                                             input logic rx_empty,
                                             input logic ovf);
    logic [7:0] s;
    s           = '0;
    s[TX_FULL]  = tx_full;
    s[RX_EMPTY] = rx_empty;
    s[OVF]      = ovf;
    return s;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: synchronous byte FIFO, DEPTH entries (power of two, >= 2).
// Pop is ignored when empty; a push into a full FIFO is accepted only when
// a pop happens in the same cycle, so the occupancy stays at DEPTH.
module byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [7:0]    store [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          pop_en;
  logic          push_en;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (PW+1)'(DEPTH));
  assign count   = cnt_q;
  assign head    = store[rd_ptr_q];

  // A pop frees a slot in the same cycle, so a full FIFO can still take a push
  assign pop_en  = pop & ~empty;
  assign push_en = push & (~full | pop_en);

  // Next-state for pointers (wrap naturally at DEPTH) and occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_en) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_en)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_en, pop_en})
      2'b10:   cnt_d = cnt_q + (PW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is not reset; stale entries are unreachable once pointers clear
  always_ff @(posedge clk) begin
    if (push_en) store[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/mem_resp.sv
// mem_resp: single-port byte RAM responder with an optional I/O window.
// Build option: define MEM_IO_EN to enable the I/O window (0x3xxxx), the
// TX/RX byte FIFOs and the tx_*/rx_* stream ports. Without it every
// address maps to RAM and the stream ports are tied inactive.
module mem_resp
  import mem_pkg::*;
#(
  parameter int ADDR_W     = 17,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ad,
  input  logic        wr,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam int RAM_BYTES = 1 << ADDR_W;

  logic [7:0]        ram [RAM_BYTES];
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_rdata_q;

  logic              io_sel;
  logic              ram_wr;
  logic              ram_rd;
  logic              io_rd;
  logic              io_wr;
  logic [7:0]        io_rdata;      // value an I/O read would return now

  rd_src_e           rd_src_q, rd_src_d;
  logic [7:0]        io_rdata_q, io_rdata_d;

  assign ram_addr = ad[ADDR_W-1:0];
  assign ram_wr   =  wr & ~io_sel;
  assign ram_rd   = ~wr & ~io_sel;
  assign io_wr    =  wr &  io_sel;
  assign io_rd    = ~wr &  io_sel;

`ifdef MEM_IO_EN
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          io_data_hit;
  logic          io_stat_hit;
  logic          tx_push, tx_full, tx_empty, tx_drop;
  logic [7:0]    tx_head;
  logic [CW-1:0] tx_count;
  logic          rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]    rx_head;
  logic [CW-1:0] rx_count;
  logic          ovf_q, ovf_d;
  logic          unused_io;

  assign io_sel      = is_io(ad);
  assign io_data_hit = (ad[15:0] == IO_DATA_OFS);
  assign io_stat_hit = (ad[15:0] == IO_STAT_OFS);

  // A write to the data register is dropped only when the TX FIFO is full
  // and the consumer is not draining a byte in the same cycle.
  assign tx_push = io_wr & io_data_hit;
  assign tx_drop = tx_push & tx_full & ~(tx_ready & ~tx_empty);

  assign rx_push = rx_valid & ~rx_full;
  assign rx_pop  = io_rd & io_data_hit & ~rx_empty;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_push),
    .din   (din),
    .pop   (tx_ready),
    .head  (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rx_push),
    .din   (rx_data),
    .pop   (rx_pop),
    .head  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  assign tx_valid = ~tx_empty;
  assign tx_data  = tx_head;
  assign rx_ready = ~rx_full;

  // Register read mux: data pops RX (0 when empty), status is side-effect free
  always_comb begin
    io_rdata = 8'h00;
    if (io_data_hit)      io_rdata = rx_empty ? 8'h00 : rx_head;
    else if (io_stat_hit) io_rdata = pack_status(tx_full, rx_empty, ovf_q);
  end

  // Sticky overflow: set on a dropped TX byte, cleared only by reset
  always_comb begin
    ovf_d = ovf_q | tx_drop;
  end

  // Overflow flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign unused_io = ^{ad[31:18], tx_count, rx_count};
`else
  logic unused_io;

  assign io_sel   = 1'b0;
  assign io_rdata = 8'h00;
  assign tx_valid = 1'b0;
  assign tx_data  = 8'h00;
  assign rx_ready = 1'b0;

  assign unused_io = ^{ad, tx_ready, rx_data, rx_valid, io_wr};
`endif

  // Single-port RAM: write or registered read, never both; no reset so the
  // array maps onto block RAM and keeps its contents across rst_n.
  always_ff @(posedge clk) begin
    if (ram_wr) ram[ram_addr] <= din;
    if (ram_rd) ram_rdata_q   <= ram[ram_addr];
  end

  // Track the source of the last read; writes leave both sides untouched
  always_comb begin
    rd_src_d   = rd_src_q;
    io_rdata_d = io_rdata_q;
    if (ram_rd) begin
      rd_src_d = SRC_RAM;
    end else if (io_rd) begin
      rd_src_d   = SRC_IO;
      io_rdata_d = io_rdata;
    end
  end

  // Read-path registers; reset selects the cleared I/O register so dout = 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_src_q   <= SRC_IO;
      io_rdata_q <= 8'h00;
    end else begin
      rd_src_q   <= rd_src_d;
      io_rdata_q <= io_rdata_d;
    end
  end

  // dout selects between two registers, so it is still one cycle after the address
  assign dout = (rd_src_q == SRC_RAM) ? ram_rdata_q : io_rdata_q;

endmodule

// File: tb/tb_mem_resp.sv
// tb_mem_resp: directed self-checking bench for mem_resp.
// Inputs change and outputs are sampled on the falling clock edge.
// The I/O window tests are built only when MEM_IO_EN is defined; otherwise
// the bench checks that the window address aliases into RAM.
module tb_mem_resp;

  localparam int          ADDR_W  = 17;
  localparam int          DEPTH   = 8;
  localparam logic [31:0] IO_DATA = 32'h0003_0000;
  localparam logic [31:0] IO_STAT = 32'h0003_0004;
  localparam logic [31:0] PARK    = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ad;
  logic        wr;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_resp #(.ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ad       (ad),
    .wr       (wr),
    .din      (din),
    .dout     (dout),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("  ok   %-22s = 0x%0h", tag, got);
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One bus write; returns on the next falling edge with the bus parked
  task automatic bus_write(input logic [31:0] a, input logic [7:0] d);
    ad  = a;
    wr  = 1'b1;
    din = d;
    @(negedge clk);
    ad  = PARK;
    wr  = 1'b0;
    din = 8'h00;
  endtask

  // One bus read; dout holds the result when this returns
  task automatic bus_read(input logic [31:0] a);
    ad = a;
    wr = 1'b0;
    @(negedge clk);
    ad = PARK;
  endtask

  // Offer one byte on the RX stream for one cycle
  task automatic rx_send(input logic [7:0] d);
    rx_valid = 1'b1;
    rx_data  = d;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  // Drain n bytes from TX with tx_ready high, checking order from first
  task automatic tx_drain(input int n, input logic [7:0] first);
    tx_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      check($sformatf("tx_valid drain %0d", i), {31'b0, tx_valid}, 32'd1);
      check($sformatf("tx_data drain %0d", i), {24'b0, tx_data}, 32'(8'(first + 8'(i))));
      @(negedge clk);
    end
    tx_ready = 1'b0;
    check("tx_valid drained", {31'b0, tx_valid}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] pat [4];
    pat = '{8'h13, 8'h57, 8'h9B, 8'hDF};

    rst_n    = 1'b0;
    ad       = PARK;
    wr       = 1'b0;
    din      = 8'h00;
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst dout", {24'b0, dout}, 32'h0);
    check("rst tx_valid", {31'b0, tx_valid}, 32'd0);
`ifdef MEM_IO_EN
    check("rst rx_ready", {31'b0, rx_ready}, 32'd1);
`else
    check("rst rx_ready", {31'b0, rx_ready}, 32'd0);
    check("rst tx_data", {24'b0, tx_data}, 32'h0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // RAM write then read, and a write leaves dout alone
    bus_write(32'h10, 8'hA5);
    bus_read(32'h10);
    check("ram rd 0x10", {24'b0, dout}, 32'hA5);
    bus_write(32'h10, 8'h3C);
    check("dout held over write", {24'b0, dout}, 32'hA5);
    bus_read(32'h10);
    check("ram rd 0x10 again", {24'b0, dout}, 32'h3C);

    // Streaming reads on consecutive cycles
    for (int i = 0; i < 4; i++) bus_write(32'h100 + 32'(i), pat[i]);
    ad = 32'h100;
    wr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("stream rd %0d", i), {24'b0, dout}, {24'b0, pat[i]});
      ad = (i < 3) ? 32'h101 + 32'(i) : PARK;
    end

`ifdef MEM_IO_EN
    // RX path: two bytes in, read back in order, then empty returns 0
    check("rx_ready idle", {31'b0, rx_ready}, 32'd1);
    rx_send(8'h11);
    rx_send(8'h22);
    bus_read(IO_DATA);
    check("rx rd 1", {24'b0, dout}, 32'h11);
    bus_read(IO_DATA);
    check("rx rd 2", {24'b0, dout}, 32'h22);
    bus_read(IO_DATA);
    check("rx rd empty", {24'b0, dout}, 32'h00);
    bus_read(IO_STAT);
    check("stat after rx", {24'b0, dout}, 32'h02);
    bus_read(32'h0003_0008);
    check("unmapped io rd", {24'b0, dout}, 32'h00);
    bus_write(IO_STAT, 8'hFF);
    bus_read(IO_STAT);
    check("stat write ignored", {24'b0, dout}, 32'h02);

    // Full TX FIFO: a write with a same-cycle pop is accepted, no overflow
    for (int i = 0; i < 8; i++) bus_write(IO_DATA, 8'(8'hA0 + 8'(i)));
    check("tx_valid full", {31'b0, tx_valid}, 32'd1);
    check("tx_data head A0", {24'b0, tx_data}, 32'hA0);
    bus_read(IO_STAT);
    check("stat tx full", {24'b0, dout}, 32'h03);
    tx_ready = 1'b1;
    bus_write(IO_DATA, 8'hA8);
    tx_ready = 1'b0;
    bus_read(IO_STAT);
    check("stat push+pop full", {24'b0, dout}, 32'h03);
    tx_drain(8, 8'hA1);

    // Overflow: ninth byte dropped while RX holds one byte
    rx_send(8'h5A);
    for (int i = 0; i < 9; i++) bus_write(IO_DATA, 8'(8'hB0 + 8'(i)));
    check("tx_valid ovf", {31'b0, tx_valid}, 32'd1);
    bus_read(IO_STAT);
    check("stat ovf", {24'b0, dout}, 32'h05);
    tx_drain(8, 8'hB0);
    bus_read(IO_DATA);
    check("rx rd 5A", {24'b0, dout}, 32'h5A);
    bus_read(IO_STAT);
    check("stat ovf sticky", {24'b0, dout}, 32'h06);

    // Half-full FIFOs, then asynchronous reset mid-cycle
    for (int i = 0; i < 4; i++) bus_write(IO_DATA, 8'(8'hC0 + 8'(i)));
    for (int i = 0; i < 4; i++) rx_send(8'(8'hD0 + 8'(i)));
    check("pre-rst tx_valid", {31'b0, tx_valid}, 32'd1);
    bus_read(IO_STAT);
    check("pre-rst stat", {24'b0, dout}, 32'h04);
`endif

    bus_read(32'h10);
    check("pre-rst ram rd", {24'b0, dout}, 32'h3C);
    #2 rst_n = 1'b0;
    #1;
    check("async rst dout", {24'b0, dout}, 32'h0);
    check("async rst tx_valid", {31'b0, tx_valid}, 32'd0);
`ifdef MEM_IO_EN
    check("async rst rx_ready", {31'b0, rx_ready}, 32'd1);
`else
    check("async rst rx_ready", {31'b0, rx_ready}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

`ifdef MEM_IO_EN
    bus_read(IO_STAT);
    check("post-rst stat", {24'b0, dout}, 32'h02);
    check("post-rst tx_valid", {31'b0, tx_valid}, 32'd0);
    bus_read(IO_DATA);
    check("post-rst rx empty", {24'b0, dout}, 32'h00);
`else
    // Without the I/O window, 0x30000 aliases RAM byte 0x10000
    bus_write(IO_DATA, 8'h77);
    bus_read(32'h0001_0000);
    check("io alias ram", {24'b0, dout}, 32'h77);
    check("no io tx_valid", {31'b0, tx_valid}, 32'd0);
`endif
    bus_read(32'h10);
    check("ram kept over rst", {24'b0, dout}, 32'h3C);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
